// File: rtl/psum_accumulator.sv
// rtl/psum_accumulator.sv - accumulates partial-sum vectors per tile, then shifts, saturates and hands off downstream
module psum_accumulator #(
    parameter int DATA_WIDTH  = 16,
    parameter int ACC_WIDTH   = 32,
    parameter int LENGTH      = 32,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_last,
    input  logic [ACC_WIDTH-1:0]   psum [0:LENGTH-1],
    input  logic [SHIFT_WIDTH-1:0] shift,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  Out [0:LENGTH-1],
    output logic                   sat_flag
);

    typedef enum logic {ACCUM, HOLD} state_t;

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(2**(DATA_WIDTH-1) - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;
    localparam logic [DATA_WIDTH-1:0] Q_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] Q_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    state_t                       state;
    logic                         first;
    logic signed [ACC_WIDTH-1:0]  acc     [0:LENGTH-1];
    logic signed [ACC_WIDTH-1:0]  nsum    [0:LENGTH-1];
    logic signed [ACC_WIDTH-1:0]  shifted [0:LENGTH-1];
    logic [DATA_WIDTH-1:0]        qval    [0:LENGTH-1];
    logic                         sat_any;
    logic                         accept;

    // in_ready depends only on state, so out_ready never reaches it combinationally
    assign in_ready = (state == ACCUM);
    assign accept   = in_valid && in_ready;

    always_comb begin
        sat_any = 1'b0;
        for (int i = 0; i < LENGTH; i++) begin
            nsum[i]    = first ? $signed(psum[i]) : acc[i] + $signed(psum[i]);
            shifted[i] = nsum[i] >>> shift;
            if (shifted[i] > SAT_MAX) begin
                qval[i] = Q_MAX;
                sat_any = 1'b1;
            end else if (shifted[i] < SAT_MIN) begin
                qval[i] = Q_MIN;
                sat_any = 1'b1;
            end else begin
                qval[i] = shifted[i][DATA_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ACCUM;
            first     <= 1'b1;
            out_valid <= 1'b0;
            sat_flag  <= 1'b0;
            for (int i = 0; i < LENGTH; i++) begin
                acc[i] <= '0;
                Out[i] <= '0;
            end
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        if (in_last) begin
                            for (int i = 0; i < LENGTH; i++) Out[i] <= qval[i];
                            sat_flag  <= sat_any;
                            out_valid <= 1'b1;
                            first     <= 1'b1;
                            state     <= HOLD;
                        end else begin
                            for (int i = 0; i < LENGTH; i++) acc[i] <= nsum[i];
                            first <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        first     <= 1'b1;
                        state     <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_psum_accumulator.sv
// tb/tb_psum_accumulator.sv - directed vector bench for psum_accumulator with LENGTH = 4
module tb_psum_accumulator;

    localparam int DW = 16;
    localparam int AW = 32;
    localparam int L  = 4;
    localparam int SW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic          in_last;
    logic [AW-1:0] psum [0:L-1];
    logic [SW-1:0] shift;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] Out [0:L-1];
    logic          sat_flag;

    int checks = 0;
    int errors = 0;

    psum_accumulator #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .LENGTH(L), .SHIFT_WIDTH(SW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .psum(psum), .shift(shift), .out_valid(out_valid), .out_ready(out_ready),
        .Out(Out), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [L-1:0][AW-1:0] p;
        logic [SW-1:0]        sh;
        logic [L-1:0][DW-1:0] e;
        logic                 s;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Present one beat at the negedge and let the next posedge accept it.
    task automatic send_beat(input logic [L-1:0][AW-1:0] p, input logic last, input logic [SW-1:0] sh);
        int n;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_last  = last;
        shift    = sh;
        for (int i = 0; i < L; i++) psum[i] = p[i];
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called #1 after the accepting edge of the last beat, with out_ready high.
    task automatic check_result(input string name, input logic [L-1:0][DW-1:0] e, input logic s);
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        for (int i = 0; i < L; i++)
            chk($sformatf("%s_out%0d", name, i), 32'(Out[i]), 32'(e[i]));
        chk({name, "_sat"}, 32'(sat_flag), 32'(s));
        @(posedge clk);
        #1;
        chk({name, "_valid_drop"}, 32'(out_valid), 32'd0);
        chk({name, "_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    function automatic logic [L-1:0][AW-1:0] lanes(input logic [AW-1:0] a, input logic [AW-1:0] b,
                                                   input logic [AW-1:0] c, input logic [AW-1:0] d);
        logic [L-1:0][AW-1:0] r;
        r[0] = a; r[1] = b; r[2] = c; r[3] = d;
        return r;
    endfunction

    function automatic logic [L-1:0][DW-1:0] qlanes(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                                    input logic [DW-1:0] c, input logic [DW-1:0] d);
        logic [L-1:0][DW-1:0] r;
        r[0] = a; r[1] = b; r[2] = c; r[3] = d;
        return r;
    endfunction

    initial begin
        tbl[0] = '{p: lanes(-32'sd5, 0, 1, 100), sh: 5'd1,
                   e: qlanes(16'hFFFD, 16'h0000, 16'h0000, 16'd50), s: 1'b0};
        tbl[1] = '{p: lanes(32'h0010_0000, 32'hFFF0_0000, 32'h0000_7FFF, 32'hFFFF_8000), sh: 5'd0,
                   e: qlanes(16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000), s: 1'b1};
        tbl[2] = '{p: lanes(32'h0000_8000, 32'hFFFF_7FFF, 0, 0), sh: 5'd0,
                   e: qlanes(16'h7FFF, 16'h8000, 16'h0000, 16'h0000), s: 1'b1};
        tbl[3] = '{p: lanes(32'h0000_8000, 32'hFFFF_7FFF, 0, 0), sh: 5'd1,
                   e: qlanes(16'h4000, 16'hBFFF, 16'h0000, 16'h0000), s: 1'b0};
        tbl[4] = '{p: lanes(32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1234_5678), sh: 5'd31,
                   e: qlanes(16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000), s: 1'b0};
        tbl[5] = '{p: lanes(32'h1234_5678, 32'hFFFF_0000, 32'h7FFF_0000, 32'h8000_0000), sh: 5'd16,
                   e: qlanes(16'h1234, 16'hFFFF, 16'h7FFF, 16'h8000), s: 1'b0};
        tbl[6] = '{p: lanes(32'h4000_0000, 0, 0, 0), sh: 5'd15,
                   e: qlanes(16'h7FFF, 16'h0000, 16'h0000, 16'h0000), s: 1'b1};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        shift     = '0;
        out_ready = 1'b1;
        for (int i = 0; i < L; i++) psum[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sat", 32'(sat_flag), 32'd0);
        chk("rst_out0", 32'(Out[0]), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        for (int v = 0; v < 7; v++) begin
            send_beat(tbl[v].p, 1'b1, tbl[v].sh);
            check_result($sformatf("vec%0d", v), tbl[v].e, tbl[v].s);
        end

        // three-beat tile: 600 >>> 2 = 150, result visible only after the last beat
        send_beat(lanes(100, 0, 0, 0), 1'b0, 5'd2);
        send_beat(lanes(200, 0, 0, 0), 1'b0, 5'd2);
        chk("basic_no_early_valid", 32'(out_valid), 32'd0);
        send_beat(lanes(300, 0, 0, 0), 1'b1, 5'd2);
        check_result("basic", qlanes(16'd150, 0, 0, 0), 1'b0);

        // accumulator wraps to the most negative value
        send_beat(lanes(32'h7FFF_FFFF, 0, 0, 0), 1'b0, 5'd0);
        send_beat(lanes(32'h0000_0001, 0, 0, 0), 1'b1, 5'd0);
        check_result("wrap", qlanes(16'h8000, 0, 0, 0), 1'b1);

        // backpressure: offered beats during HOLD must be ignored
        out_ready = 1'b0;
        send_beat(lanes(42, 0, 0, 0), 1'b1, 5'd0);
        chk("bp_valid_rise", 32'(out_valid), 32'd1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_last  = 1'b0;
            psum[0]  = 32'd999;
            @(posedge clk);
            #1;
            chk($sformatf("bp_in_ready%0d", c), 32'(in_ready), 32'd0);
            chk($sformatf("bp_valid%0d", c), 32'(out_valid), 32'd1);
            chk($sformatf("bp_out%0d", c), 32'(Out[0]), 32'd42);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_handshake_valid", 32'(out_valid), 32'd0);
        send_beat(lanes(5, 0, 0, 0), 1'b1, 5'd0);
        check_result("bp_fresh", qlanes(16'd5, 0, 0, 0), 1'b0);

        // back-to-back tiles, no residue carried across
        send_beat(lanes(10, 0, 0, 0), 1'b0, 5'd0);
        send_beat(lanes(20, 0, 0, 0), 1'b1, 5'd0);
        check_result("b2b_a", qlanes(16'd30, 0, 0, 0), 1'b0);
        send_beat(lanes(7, 0, 0, 0), 1'b1, 5'd0);
        check_result("b2b_b", qlanes(16'd7, 0, 0, 0), 1'b0);

        // reset mid-tile discards the partial sum and clears Out
        send_beat(lanes(1000, 0, 0, 0), 1'b0, 5'd0);
        send_beat(lanes(1000, 0, 0, 0), 1'b0, 5'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_out0", 32'(Out[0]), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        send_beat(lanes(5, 0, 0, 0), 1'b1, 5'd0);
        check_result("midrst", qlanes(16'd5, 0, 0, 0), 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
